// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: baud codes, divisor table, 8N1 frame constants and TX FSM states.
// The receiver is expected to import this package as well.
package uart_tx_pkg;

    localparam int DATA_W     = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_W + STOP_BITS;
    localparam int CNT_W      = 16;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Divisors are bit period minus one at a 50 MHz system clock.
    localparam logic [CNT_W-1:0] DIV_9600   = 16'd5207;
    localparam logic [CNT_W-1:0] DIV_19200  = 16'd2603;
    localparam logic [CNT_W-1:0] DIV_38400  = 16'd1301;
    localparam logic [CNT_W-1:0] DIV_57600  = 16'd867;
    localparam logic [CNT_W-1:0] DIV_115200 = 16'd433;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [CNT_W-1:0] baud_divisor(input logic [2:0] code);
        case (code)
            BAUD_19200:  return DIV_19200;
            BAUD_38400:  return DIV_38400;
            BAUD_57600:  return DIV_57600;
            BAUD_115200: return DIV_115200;
            default:     return DIV_9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Upstream-facing UART transmit bundle: rate select, request/data in, serial line and status out.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [2:0]        baud_set;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data_in;
    logic              tx_data_out;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output baud_set,
        output tx_start,
        output tx_data_in,
        input  tx_data_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  baud_set,
        input  tx_start,
        input  tx_data_in,
        output tx_data_out,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_div.sv
// Bit-period timer: latches the divisor on restart and flags the last cycle of every bit period.
module uart_baud_div
    import uart_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       baud_set_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] bps_dr_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] bps_q, bps_d;

    // Divisor is captured only on restart, so baud_set changes mid-frame are invisible.
    always_comb begin
        bps_d = bps_q;
        cnt_d = cnt_q + 16'd1;
        if (restart_i) begin
            bps_d = baud_divisor(baud_set_i);
            cnt_d = '0;
        end else if (cnt_q == bps_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            bps_q <= DIV_9600;
        end else begin
            cnt_q <= cnt_d;
            bps_q <= bps_d;
        end
    end

    assign bps_dr_o = bps_q;
    assign tick_o   = (cnt_q == bps_q);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per request and shifts it out LSB first.
// All outputs are registered; tx_done pulses for one cycle as the stop bit ends.
module uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DATA_W = 8
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus
);
    import uart_tx_pkg::CNT_W;
    import uart_tx_pkg::tx_state_e;
    import uart_tx_pkg::IDLE;
    import uart_tx_pkg::START;
    import uart_tx_pkg::DATA;
    import uart_tx_pkg::STOP;

    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    if (CLK_HZ != 50_000_000 || DATA_W != 8) begin : g_unsupported
        $error("uart_tx: divisor table assumes a 50 MHz clock and 8 data bits");
    end

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idxNext;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              restart;
    logic              tick;
    logic [CNT_W-1:0]  bpsDr;

    uart_baud_div u_baud_div (
        .clk        (clk),
        .reset      (reset),
        .baud_set_i (bus.baud_set),
        .restart_i  (restart),
        .bps_dr_o   (bpsDr),
        .tick_o     (tick)
    );

    assign idxNext = idx_q + IDX_W'(1);

    // Next-state and registered-output values; the line level for each bit is decided one edge early.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_start) begin
                    restart = 1'b1;
                    shift_d = bus.tx_data_in;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idxNext;
                        tx_d  = shift_q[idxNext];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_data_out = tx_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_done     = done_q;

    logic unusedBps;
    assign unusedBps = ^bpsDr;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames are compared cycle by cycle against an ideal 8N1 waveform.
module tb_uart_tx;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    always #10 clk = ~clk;

    uart_tx_if bus ();

    uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bit period straight from the nominal baud rate and the 50 MHz clock.
    function automatic int bitPeriod(input logic [2:0] code);
        int baud;
        case (code)
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            default: baud = 9600;
        endcase
        return 50_000_000 / baud;
    endfunction

    task automatic startFrame(input logic [7:0] d, input logic [2:0] code);
        @(negedge clk);
        bus.baud_set   = code;
        bus.tx_data_in = d;
        bus.tx_start   = 1'b1;
    endtask

    // Follows one frame from the cycle after acceptance through the tx_done cycle.
    task automatic checkFrame(input logic [7:0] d, input int n, input bit hold,
                              input logic [7:0] nextData, input int disturbAt,
                              input logic [2:0] newBaud, input string name);
        logic frameBits [10];
        int   slotErr [10] = '{default: 0};
        int   busyErr = 0;
        int   doneErr = 0;
        frameBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frameBits[i+1] = d[i];
        frameBits[9] = 1'b1;
        for (int c = 0; c < 10 * n; c++) begin
            @(negedge clk);
            if (bus.tx_data_out !== frameBits[c/n]) slotErr[c/n]++;
            if (bus.tx_busy !== 1'b1) busyErr++;
            if (bus.tx_done !== 1'b0) doneErr++;
            if (c == 0) begin
                if (!hold) bus.tx_start = 1'b0;
                bus.tx_data_in = hold ? nextData : 8'($urandom);
            end
            if (c == disturbAt) begin
                bus.tx_start   = 1'b1;
                bus.tx_data_in = 8'($urandom);
                bus.baud_set   = newBaud;
            end
            if (disturbAt >= 0 && c == disturbAt + 1) bus.tx_start = 1'b0;
        end
        @(negedge clk);
        assertCount++;
        if (bus.tx_done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s done: tx_done=%b, required 1", name, bus.tx_done);
        end
        assertCount++;
        if (bus.tx_busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s idle busy: tx_busy=%b, required 0", name, bus.tx_busy);
        end
        assertCount++;
        if (bus.tx_data_out !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s idle line: tx_data_out=%b, required 1", name, bus.tx_data_out);
        end
        for (int s = 0; s < 10; s++) begin
            assertCount++;
            if (slotErr[s] !== 0) begin
                failCount++;
                $display("[TB] FAIL %s slot %0d: %0d cycles not %b, required 0", name, s, slotErr[s], frameBits[s]);
            end
        end
        assertCount++;
        if (busyErr !== 0) begin
            failCount++;
            $display("[TB] FAIL %s busy: low for %0d frame cycles, required 0", name, busyErr);
        end
        assertCount++;
        if (doneErr !== 0) begin
            failCount++;
            $display("[TB] FAIL %s early done: high for %0d frame cycles, required 0", name, doneErr);
        end
    endtask

    task automatic checkIdle(input int cycles, input string name);
        int errs = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.tx_data_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) errs++;
        end
        assertCount++;
        if (errs !== 0) begin
            failCount++;
            $display("[TB] FAIL %s idle: %0d bad cycles, required 0", name, errs);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        assertCount++;
        if ({bus.tx_data_out, bus.tx_busy, bus.tx_done} !== 3'b100) begin
            failCount++;
            $display("[TB] FAIL %s: out/busy/done=%b%b%b, required 100", name,
                     bus.tx_data_out, bus.tx_busy, bus.tx_done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #5 reset = 1'b1;
        #1 checkResetOutputs("async reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkIdle(5, "after reset");
    endtask

    task automatic test_single();
        startFrame(8'h55, 3'd4);
        checkFrame(8'h55, bitPeriod(3'd4), 1'b0, 8'h00, -1, 3'd4, "single 0x55");
        checkIdle(3, "single 0x55 done pulse");
    endtask

    task automatic test_back_to_back();
        int n = bitPeriod(3'd3);
        startFrame(8'h00, 3'd3);
        checkFrame(8'h00, n, 1'b1, 8'hFF, -1, 3'd3, "b2b first");
        checkFrame(8'hFF, n, 1'b0, 8'h00, -1, 3'd3, "b2b second");
        checkIdle(3, "b2b tail");
    endtask

    task automatic test_midframe();
        logic [7:0] d = 8'($urandom);
        logic [2:0] slowCodes [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
        logic [2:0] newBaud = slowCodes[$urandom_range(0, 3)];
        int         n4 = bitPeriod(3'd4);
        $display("[TB] mid-frame request with data 0x%02h, baud_set -> %0d", d, newBaud);
        startFrame(d, 3'd4);
        checkFrame(d, n4, 1'b0, 8'h00, 5 * n4 + 17, newBaud, "midframe");
        checkIdle(20, "ignored request");
        startFrame(8'hA3, newBaud);
        checkFrame(8'hA3, bitPeriod(newBaud), 1'b0, 8'h00, -1, newBaud, "slow 0xA3");
        checkIdle(3, "slow 0xA3 tail");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d = 8'($urandom);
        int         n = bitPeriod(3'd4);
        int         k = 4 * n + 1 + $urandom_range(0, n - 2);
        startFrame(d, 3'd4);
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            if (c == 0) bus.tx_start = 1'b0;
        end
        @(posedge clk);
        #5 reset = 1'b1;
        #1 checkResetOutputs("reset mid-frame");
        checkIdle(4, "held in reset");
        reset = 1'b0;
        checkIdle(4, "after mid-frame reset");
        startFrame(8'h81, 3'd4);
        checkFrame(8'h81, n, 1'b0, 8'h00, -1, 3'd4, "post-reset 0x81");
        checkIdle(3, "post-reset tail");
    endtask

    initial begin
        bus.baud_set   = 3'd0;
        bus.tx_start   = 1'b0;
        bus.tx_data_in = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_midframe();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
